cache_controller_mp: RTL



---
 rtl/cache_controller_mp.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cache_controller_mp.sv
// Multi-port L1 cache controller: round-robin miss arbitration over N_PORTS caches,
// line transfers sequenced through a shared line buffer to one main-memory port.
module cache_controller_mp #(
    parameter int N_PORTS        = 2,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE),
    parameter int PTR_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PORTS-1:0] re,
    input  logic [N_PORTS-1:0] we_cpu,
    input  logic [N_PORTS-1:0] hit,
    input  logic [N_PORTS-1:0] dirty,
    input  logic               mem_valid_mm,
    output logic               clr,
    output logic [N_PORTS-1:0] mem_valid,
    output logic [PTR_W-1:0]   sel_port,
    output logic [IDX_W-1:0]   cl_idx,
    output logic               we_cl,
    output logic [N_PORTS-1:0] we_l1,
    output logic               re_mm,
    output logic               we_mm,
    output logic               busy
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        CHECK    = 3'd1,
        WB_COPY  = 3'd2,
        WB_MM    = 3'd3,
        FETCH_MM = 3'd4,
        FILL_L1  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cl_idx_q, cl_idx_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;

    logic [N_PORTS-1:0] miss;
    logic [N_PORTS-1:0] rot;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   grant;
    logic               found;
    logic               last;
    logic [IDX_W-1:0]   idx_inc;
    logic [PTR_W-1:0]   next_owner;

    assign cl_idx = cl_idx_q;
    assign miss   = ~hit & (re | we_cpu);

    // Rotate the miss vector so bit 0 is the port at rr; first set bit gives the offset.
    always_comb begin
        rot   = N_PORTS'({miss, miss} >> rr_q);
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_q} + (PTR_W+1)'(k);
            end
        end
        grant = (sum >= (PTR_W+1)'(N_PORTS)) ? PTR_W'(sum - (PTR_W+1)'(N_PORTS))
                                              : sum[PTR_W-1:0];
    end

    assign last       = (cl_idx_q == IDX_W'(WORDS_PER_LINE-1));
    assign idx_inc    = cl_idx_q + IDX_W'(1);
    assign next_owner = (owner_q == PTR_W'(N_PORTS-1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        cl_idx_d  = cl_idx_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        clr       = 1'b0;
        mem_valid = '0;
        sel_port  = '0;
        we_cl     = 1'b0;
        we_l1     = '0;
        re_mm     = 1'b0;
        we_mm     = 1'b0;
        busy      = 1'b0;
        case (state_q)
            INIT: begin
                clr      = 1'b1;
                cl_idx_d = '0;
                rr_d     = '0;
                state_d  = CHECK;
            end
            CHECK: begin
                mem_valid = hit & (re | we_cpu);
                if (|miss) begin
                    owner_d = grant;
                    state_d = dirty[grant] ? WB_COPY : FETCH_MM;
                end
            end
            WB_COPY: begin
                sel_port = owner_q;
                busy     = 1'b1;
                we_cl    = 1'b1;
                cl_idx_d = idx_inc;
                if (last) begin
                    cl_idx_d = '0;
                    state_d  = WB_MM;
                end
            end
            WB_MM: begin
                sel_port = owner_q;
                busy     = 1'b1;
                we_mm    = 1'b1;
                if (mem_valid_mm) begin
                    cl_idx_d = idx_inc;
                    if (last) begin
                        cl_idx_d = '0;
                        state_d  = FETCH_MM;
                    end
                end
            end
            FETCH_MM: begin
                sel_port = owner_q;
                busy     = 1'b1;
                re_mm    = 1'b1;
                we_cl    = mem_valid_mm;
                if (mem_valid_mm) begin
                    cl_idx_d = idx_inc;
                    if (last) begin
                        cl_idx_d = '0;
                        state_d  = FILL_L1;
                    end
                end
            end
            FILL_L1: begin
                sel_port       = owner_q;
                busy           = 1'b1;
                we_l1[owner_q] = 1'b1;
                cl_idx_d       = idx_inc;
                if (last) begin
                    // Pointer moves only once the line is fully installed.
                    cl_idx_d = '0;
                    rr_d     = next_owner;
                    state_d  = CHECK;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            cl_idx_q <= '0;
            rr_q     <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            cl_idx_q <= cl_idx_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
        end
    end

endmodule
